// File: rtl/alu_pkg.sv
// Shared function encodings and FSM state type for the sequential ALU.
// Imported by alu_seq.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle (present only with ALU_SEQ_MUL_EN).
// Latency: o_done asserted WIDTH-1 cycles after the i_start edge. Backpressure: caller must not restart while busy.
`ifdef ALU_SEQ_MUL_EN
module alu_mul_seq #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_prod_hi,
    output logic [WIDTH-1:0] o_prod_lo
);

    logic             r_busy;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_hi_in;
    logic [WIDTH-1:0] w_lo_in;
    logic [WIDTH-1:0] w_mcand_in;
    logic [WIDTH:0]   w_sum;

    // The first iteration runs on the start edge itself, so WIDTH steps finish WIDTH-1 edges later.
    always_comb begin
        w_hi_in    = i_start ? '0  : r_hi;
        w_lo_in    = i_start ? i_b : r_lo;
        w_mcand_in = i_start ? i_a : r_mcand;
        w_sum      = {1'b0, w_hi_in} + (w_lo_in[0] ? {1'b0, w_mcand_in} : '0);
    end

    assign o_done    = r_busy && (r_cnt == SHW'(WIDTH - 1));
    assign o_prod_hi = r_hi;
    assign o_prod_lo = r_lo;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_mcand <= i_a;
            r_hi    <= w_sum[WIDTH:1];
            r_lo    <= {w_sum[0], w_lo_in[WIDTH-1:1]};
        end else if (r_busy) begin
            if (o_done) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_hi  <= w_sum[WIDTH:1];
                r_lo  <= {w_sum[0], w_lo_in[WIDTH-1:1]};
            end
        end
    end

endmodule
`endif

// File: rtl/alu_uadd.sv
// Unsigned WIDTH-bit adder with carry-in/carry-out.
// Latency: combinational. Backpressure: none.
module alu_uadd #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum  = w_full[WIDTH-1:0];
    assign o_cout = w_full[WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/ready/valid handshake; MUL enabled by ALU_SEQ_MUL_EN.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for MUL. Backpressure: o_ready low while MUL runs.
module alu_seq #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [2:0]       i_func,
    input  logic [WIDTH-1:0] i_s1,
    input  logic [WIDTH-1:0] i_s2,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_zero,
    output logic             o_negative,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_illegal
);
    import alu_pkg::*;

    alu_state_t       r_state;
    alu_state_t       w_state_nxt;
    logic             w_ready;
    logic             w_load_alu;
    logic             w_load_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_prod_hi;
    logic [WIDTH-1:0] w_prod_lo;

    logic             w_sub;
    logic [WIDTH-1:0] w_add_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_shl_res;
    logic             w_shl_c;
    logic [WIDTH-1:0] w_shr_res;
    logic             w_shr_c;

    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_ill;

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_negative;
    logic             r_carry;
    logic             r_overflow;
    logic             r_illegal;

    // SUB is s1 + ~s2 + 1; borrow is the inverted carry-out.
    assign w_sub   = (i_func == ALU_SUB);
    assign w_add_b = w_sub ? ~i_s2 : i_s2;
    assign w_shamt = i_s2[SHW-1:0];

    alu_uadd #(.WIDTH(WIDTH)) u_uadd (
        .i_a    (i_s1),
        .i_b    (w_add_b),
        .i_cin  (w_sub),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // The extra bit catches the last bit shifted out; a zero shift leaves it 0.
    assign {w_shl_c, w_shl_res} = {1'b0, i_s1} << w_shamt;
    assign {w_shr_res, w_shr_c} = {i_s1, 1'b0} >> w_shamt;

`ifdef ALU_SEQ_MUL_EN
    logic w_mul_start;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (w_mul_start),
        .i_a       (i_s1),
        .i_b       (i_s2),
        .o_done    (w_mul_done),
        .o_prod_hi (w_prod_hi),
        .o_prod_lo (w_prod_lo)
    );
`else
    assign w_mul_done = 1'b0;
    assign w_prod_hi  = '0;
    assign w_prod_lo  = '0;
`endif

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (i_func)
            ALU_ADD, ALU_SUB: begin
                w_res = w_sum;
                w_c   = w_sub ? ~w_cout : w_cout;
                w_v   = (i_s1[WIDTH-1] == w_add_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_s1[WIDTH-1]);
            end
            ALU_AND: w_res = i_s1 & i_s2;
            ALU_OR:  w_res = i_s1 | i_s2;
            ALU_XOR: w_res = i_s1 ^ i_s2;
            ALU_SHL: begin
                w_res = w_shl_res;
                w_c   = w_shl_c;
            end
            ALU_SHR: begin
                w_res = w_shr_res;
                w_c   = w_shr_c;
            end
            ALU_MUL: begin
`ifndef ALU_SEQ_MUL_EN
                w_ill = 1'b1;
`endif
            end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_load_alu  = 1'b0;
        w_load_mul  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        w_mul_start = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (i_en) begin
`ifdef ALU_SEQ_MUL_EN
                    if (i_func == ALU_MUL) begin
                        w_mul_start = 1'b1;
                        w_state_nxt = MUL_RUN;
                    end else begin
                        w_load_alu = 1'b1;
                    end
`else
                    w_load_alu = 1'b1;
`endif
                end
            end
            MUL_RUN: begin
                if (w_mul_done) begin
                    w_load_mul  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_valid <= w_load_alu | w_load_mul;
            if (w_load_alu) begin
                r_result    <= w_res;
                r_result_hi <= '0;
                r_zero      <= (w_res == '0) && !w_ill;
                r_negative  <= w_res[WIDTH-1];
                r_carry     <= w_c;
                r_overflow  <= w_v;
                r_illegal   <= w_ill;
            end else if (w_load_mul) begin
                r_result    <= w_prod_lo;
                r_result_hi <= w_prod_hi;
                r_zero      <= (w_prod_lo == '0);
                r_negative  <= w_prod_lo[WIDTH-1];
                r_carry     <= 1'b0;
                r_overflow  <= |w_prod_hi;
                r_illegal   <= 1'b0;
            end
        end
    end

    assign o_ready     = w_ready;
    assign o_valid     = r_valid;
    assign o_result    = r_result;
    assign o_result_hi = r_result_hi;
    assign o_zero      = r_zero;
    assign o_negative  = r_negative;
    assign o_carry     = r_carry;
    assign o_overflow  = r_overflow;
    assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); MUL scenarios compiled with ALU_SEQ_MUL_EN.
// Observed vector layout: {valid, ready, result_hi, result, Z, N, C, V, illegal}.
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] func;
    logic [7:0] s1;
    logic [7:0] s2;
    logic       o_ready;
    logic       o_valid;
    logic [7:0] o_result;
    logic [7:0] o_result_hi;
    logic       o_zero;
    logic       o_negative;
    logic       o_carry;
    logic       o_overflow;
    logic       o_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_func      (func),
        .i_s1        (s1),
        .i_s2        (s2),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_result    (o_result),
        .o_result_hi (o_result_hi),
        .o_zero      (o_zero),
        .o_negative  (o_negative),
        .o_carry     (o_carry),
        .o_overflow  (o_overflow),
        .o_illegal   (o_illegal)
    );

    function automatic logic [22:0] obs();
        return {o_valid, o_ready, o_result_hi, o_result, o_zero, o_negative, o_carry, o_overflow, o_illegal};
    endfunction

    function automatic logic [22:0] ev(input logic v, input logic r, input logic [7:0] hi, input logic [7:0] res,
                                       input logic z, input logic n, input logic c, input logic ov, input logic il);
        return {v, r, hi, res, z, n, c, ov, il};
    endfunction

    task automatic drive(input logic e, input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        en   = e;
        func = f;
        s1   = a;
        s2   = b;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, ALU_ADD, 8'h00, 8'h00);
        #12;
        checks++;
        if (obs() !== ev(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset: got %h expected %h", obs(), ev(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        @(negedge clk);
        drive(1'b1, ALU_ADD, 8'h7F, 8'h01);
        @(negedge clk);
        drive(1'b0, ALU_ADD, 8'hFF, 8'hFF);
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'h80, 0, 1, 0, 1, 0)) begin
            errors++;
            $display("FAIL add_ovf: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'h80, 0, 1, 0, 1, 0));
        end
        @(negedge clk);
        checks++;
        if (obs() !== ev(0, 1, 8'h00, 8'h80, 0, 1, 0, 1, 0)) begin
            errors++;
            $display("FAIL add_hold: got %h expected %h", obs(), ev(0, 1, 8'h00, 8'h80, 0, 1, 0, 1, 0));
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        drive(1'b1, ALU_SUB, 8'h05, 8'h05);
        @(negedge clk);
        drive(1'b1, ALU_SUB, 8'h03, 8'h04);
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL sub_equal: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0));
        end
        @(negedge clk);
        drive(1'b0, ALU_ADD, 8'h00, 8'h00);
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'hFF, 0, 1, 1, 0, 0)) begin
            errors++;
            $display("FAIL sub_borrow: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'hFF, 0, 1, 1, 0, 0));
        end
    endtask

    task automatic test_shift;
        @(negedge clk);
        drive(1'b1, ALU_SHL, 8'h81, 8'h01);
        @(negedge clk);
        drive(1'b1, ALU_SHR, 8'h81, 8'h00);
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'h02, 0, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL shl1: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'h02, 0, 0, 1, 0, 0));
        end
        @(negedge clk);
        drive(1'b1, ALU_SHR, 8'h81, 8'h09);
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'h81, 0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL shr0: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'h81, 0, 1, 0, 0, 0));
        end
        @(negedge clk);
        drive(1'b0, ALU_ADD, 8'h00, 8'h00);
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'h40, 0, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL shr1: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'h40, 0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_logic;
        @(negedge clk);
        drive(1'b1, ALU_AND, 8'hF0, 8'h3C);
        @(negedge clk);
        drive(1'b1, ALU_OR, 8'hF0, 8'h3C);
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'h30, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL and: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'h30, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        drive(1'b1, ALU_XOR, 8'h5A, 8'h5A);
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'hFC, 0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL or: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'hFC, 0, 1, 0, 0, 0));
        end
        @(negedge clk);
        drive(1'b0, ALU_ADD, 8'h00, 8'h00);
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL xor_zero: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0));
        end
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_mul;
        @(negedge clk);
        drive(1'b1, ALU_MUL, 8'hFF, 8'hFF);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({o_valid, o_ready} !== 2'b00) begin
                errors++;
                $display("FAIL mul_busy[%0d]: got valid,ready=%b expected 00", k, {o_valid, o_ready});
            end
            drive((k % 2 == 0) && (k < 7), ALU_ADD, 8'h01, 8'h01);
        end
        @(negedge clk);
        drive(1'b1, ALU_MUL, 8'h03, 8'h05);
        checks++;
        if (obs() !== ev(1, 1, 8'hFE, 8'h01, 0, 0, 0, 1, 0)) begin
            errors++;
            $display("FAIL mul_ff: got %h expected %h", obs(), ev(1, 1, 8'hFE, 8'h01, 0, 0, 0, 1, 0));
        end
        repeat (9) begin
            @(negedge clk);
            drive(1'b0, ALU_ADD, 8'h00, 8'h00);
        end
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'h0F, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL mul_small: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'h0F, 0, 0, 0, 0, 0));
        end
    endtask
`else
    task automatic test_illegal;
        @(negedge clk);
        drive(1'b1, ALU_MUL, 8'hFF, 8'hFF);
        @(negedge clk);
        drive(1'b1, ALU_AND, 8'h0F, 8'hF3);
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 1)) begin
            errors++;
            $display("FAIL illegal_mul: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 1));
        end
        @(negedge clk);
        drive(1'b0, ALU_ADD, 8'h00, 8'h00);
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'h03, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL illegal_clear: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'h03, 0, 0, 0, 0, 0));
        end
    endtask
`endif

    task automatic test_reset_recover;
        logic seen_valid;
        @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
        drive(1'b1, ALU_MUL, 8'h10, 8'h0C);
`else
        drive(1'b1, ALU_ADD, 8'hFF, 8'h01);
`endif
        @(negedge clk);
        drive(1'b0, ALU_ADD, 8'h00, 8'h00);
`ifndef ALU_SEQ_MUL_EN
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'h00, 1, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL add_wrap: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'h00, 1, 0, 1, 0, 0));
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== ev(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", obs(), ev(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen_valid = seen_valid | o_valid;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_silent: got valid seen=%b expected 0", seen_valid);
        end
        drive(1'b1, ALU_ADD, 8'h01, 8'h01);
        @(negedge clk);
        drive(1'b0, ALU_ADD, 8'h00, 8'h00);
        checks++;
        if (obs() !== ev(1, 1, 8'h00, 8'h02, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL post_reset_add: got %h expected %h", obs(), ev(1, 1, 8'h00, 8'h02, 0, 0, 0, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_shift();
        test_logic();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
`else
        test_illegal();
`endif
        test_reset_recover();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 8-bit combinational ALU. Executes one of eight functions on two WIDTH-bit operands with a start/ready/valid handshake. Single-cycle ops have 1-cycle latency; MUL is a multi-cycle shift-add unit. Sits between the register file read stage and writeback of the SISD core, and produces registered Z/N/C/V flags.

Parameters:
WIDTH, 8, operand/result width; power of two, >= 4
SHW, $clog2(WIDTH), shift-amount bits taken from i_s2 (derived; do not override)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  start request; accepted when i_en && o_ready
i_func  input  3  function select (encodings in alu_pkg)
i_s1  input  WIDTH  operand A
i_s2  input  WIDTH  operand B (shift amount = i_s2[SHW-1:0])
o_ready  output  1  can accept a new op this cycle
o_valid  output  1  one-cycle pulse: o_result/o_result_hi/flags are new
o_result  output  WIDTH  result (MUL: low half)
o_result_hi  output  WIDTH  MUL high half; 0 for all other ops
o_zero  output  1  o_result == 0
o_negative  output  1  o_result[WIDTH-1]
o_carry  output  1  carry/borrow/shifted-out bit
o_overflow  output  1  signed overflow (ADD/SUB); o_result_hi != 0 (MUL)
o_illegal  output  1  op not supported in this build (see Optional Feature)

Behaviour:
- Reset: all outputs 0 except o_ready = 1; state IDLE. Reset mid-MUL aborts it, no o_valid.
- Operands and func are captured on the accepting edge; later input changes have no effect on the op in flight.
- Functions: 000 ADD, 001 SUB (s1-s2), 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL (unsigned, 2*WIDTH product).
- States: IDLE, MUL_RUN.
  IDLE: o_ready = 1. Accepting a non-MUL op registers result and flags; o_valid = 1 in the next cycle; stay IDLE. Back-to-back ops accepted every cycle.
  Accepting MUL goes to MUL_RUN, with o_ready = 0 and iteration counter cleared.
  MUL_RUN: one multiplier bit per cycle for WIDTH cycles. Result, flags and o_valid are presented WIDTH cycles after the accepting edge, then return to IDLE with o_ready = 1 in that same cycle.
  i_en is ignored while o_ready = 0.
- Carry: ADD carry-out; SUB borrow (1 iff s1 < s2 unsigned); SHL last bit shifted out of the MSB; SHR last bit shifted out of bit 0; shift by 0 gives carry 0; logic ops and MUL give 0.
- Overflow: ADD/SUB two's-complement overflow; MUL o_result_hi != 0; all others 0.
- o_zero and o_negative are computed from o_result only.
- Results and flags hold their last value between o_valid pulses. o_illegal follows the same rule and is cleared by the next legal completion.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL behaves as above and the alu_mul_seq instance is present.
- Undefined: no multiplier logic and MUL_RUN is unreachable. func 111 completes in 1 cycle with o_result = o_result_hi = 0, all flags 0 and o_illegal = 1.

Decomposition:
- alu_pkg: 3-bit function encoding constants (ALU_ADD..ALU_MUL) and the state enum typedef (IDLE, MUL_RUN).
- Sub-module alu_mul_seq: shift-add multiplier with start, done, product hi/lo and internal counter.
- The top holds the handshake FSM, the single-cycle datapath (reusing alu_uadd for ADD/SUB) and the flag registers.

Test Plan:
- WIDTH=8, ADD 0x7F+0x01 -> next cycle o_valid=1, o_result=0x80, N=1, V=1, C=0, Z=0.
- SUB 0x05-0x05 then SUB 0x03-0x04 on consecutive cycles -> consecutive o_valid pulses; first Z=1 C=0; second o_result=0xFF, C=1, N=1.
- SHL 0x81 by 1 -> o_result=0x02, C=1; SHR 0x81 by 0 -> o_result=0x81, C=0.
- MUL 0xFF*0xFF (ALU_SEQ_MUL_EN) -> o_ready low 8 cycles, i_en pulses ignored; o_valid at cycle 8 with hi=0xFE, lo=0x01, V=1.
- MUL 0x10*0x0C, i_rst_n low at cycle 3 -> all outputs 0, o_ready=1, no o_valid; a following ADD 0x01+0x01 -> 0x02.
- Build without ALU_SEQ_MUL_EN, func 111 -> 1-cycle o_valid, o_illegal=1, result 0; a following AND -> o_illegal=0.
